// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register access (write or read of an 8-bit register
// on a 7-bit I2C device) into the command sequence for a byte-level I2C
// engine (cmd 1=start, 2=stop, 3=send byte, 4=read byte). It follows the
// engine's ready/data_valid handshake, captures read data, and resets a hung
// engine when a command takes longer than TIMEOUT cycles.
//
// Ports:
//   clk_i, reset_n       clock, asynchronous active-low reset
//   req, rnw             request strobe (sampled in IDLE), 1 = read
//   dev_addr, reg_addr   7-bit device address, 8-bit register index
//   wdata                byte to write
//   busy, done, err      in-progress flag, end pulse, timeout/abort pulse
//   rdata                last successfully read byte
//   i2c_cmd, i2c_cmd_en  engine command and one-cycle strobe
//   i2c_wdata            byte presented to the engine
//   i2c_rdata            byte returned by the engine
//   i2c_data_valid       engine read data valid
//   i2c_ready            engine ready
//   i2c_reset_n          engine synchronous reset, active-low
module i2c_reg_seq #(
  parameter int TIMEOUT    = 4095,
  parameter int RST_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       req,
  input  logic       rnw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic [3:0] i2c_cmd,
  output logic       i2c_cmd_en,
  output logic [7:0] i2c_wdata,
  input  logic [7:0] i2c_rdata,
  input  logic       i2c_data_valid,
  input  logic       i2c_ready,
  output logic       i2c_reset_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_FINISH, S_ABORT
  } state_t;

  localparam logic [3:0]  CMD_START = 4'd1;
  localparam logic [3:0]  CMD_STOP  = 4'd2;
  localparam logic [3:0]  CMD_SEND  = 4'd3;
  localparam logic [3:0]  CMD_READ  = 4'd4;
  localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT);
  localparam logic [7:0]  RST_LAST  = 8'(RST_CYCLES - 1);

  // Write: START, SEND dev+W, SEND reg, SEND data, STOP
  // Read:  START, SEND dev+W, SEND reg, START, SEND dev+R, READ, STOP
  function automatic logic [3:0] step_cmd(input logic rd, input logic [2:0] s);
    case (s)
      3'd0:       step_cmd = CMD_START;
      3'd1, 3'd2: step_cmd = CMD_SEND;
      3'd3:       step_cmd = rd ? CMD_START : CMD_SEND;
      3'd4:       step_cmd = rd ? CMD_SEND  : CMD_STOP;
      3'd5:       step_cmd = CMD_READ;
      default:    step_cmd = CMD_STOP;
    endcase
  endfunction

  function automatic logic [7:0] step_data(input logic rd, input logic [2:0] s,
                                           input logic [6:0] dv, input logic [7:0] ra,
                                           input logic [7:0] wd);
    case (s)
      3'd1:    step_data = {dv, 1'b0};
      3'd2:    step_data = ra;
      3'd3:    step_data = rd ? 8'h00 : wd;
      3'd4:    step_data = rd ? {dv, 1'b1} : 8'h00;
      default: step_data = 8'h00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]  rdata_q, rdata_d, wdo_q, wdo_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        cmd_en_q, cmd_en_d, irst_n_q, irst_n_d;
  logic        lat_en;
  logic        rnw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wd_q;
  logic [15:0] tmo_inc;
  logic        is_read_step, is_last_step;

  assign tmo_inc      = tmo_q + 16'd1;
  assign is_read_step = rnw_q && (step_q == 3'd5);
  assign is_last_step = (step_q == (rnw_q ? 3'd6 : 3'd4));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    tmo_d    = tmo_q;
    rcnt_d   = rcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    wdo_d    = wdo_q;
    cmd_d    = 4'd0;
    cmd_en_d = 1'b0;
    irst_n_d = irst_n_q;
    lat_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && i2c_ready) begin
          lat_en  = 1'b1;
          busy_d  = 1'b1;
          step_d  = 3'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_d    = step_cmd(rnw_q, step_q);
        wdo_d    = step_data(rnw_q, step_q, dev_q, reg_q, wd_q);
        cmd_en_d = 1'b1;
        tmo_d    = 16'd0;
        state_d  = S_WAIT_LO;
      end
      S_WAIT_LO, S_WAIT_HI: begin
        if (state_q == S_WAIT_LO && !i2c_ready) begin
          state_d = S_WAIT_HI;
        end else if (state_q == S_WAIT_HI && i2c_ready) begin
          if (is_read_step && !i2c_data_valid) begin
            // Ready without valid data on a read: treat as an engine fault.
            state_d  = S_ABORT;
            irst_n_d = 1'b0;
            rcnt_d   = 8'd0;
          end else begin
            if (is_read_step) rdata_d = i2c_rdata;
            if (is_last_step) begin
              done_d  = 1'b1;
              state_d = S_FINISH;
            end else begin
              step_d  = step_q + 3'd1;
              state_d = S_ISSUE;
            end
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIM) begin
            state_d  = S_ABORT;
            irst_n_d = 1'b0;
            rcnt_d   = 8'd0;
          end
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (rcnt_q == RST_LAST) begin
          irst_n_d = 1'b1;
          done_d   = 1'b1;
          err_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      step_q   <= 3'd0;
      tmo_q    <= 16'd0;
      rcnt_q   <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 8'h00;
      wdo_q    <= 8'h00;
      cmd_q    <= 4'd0;
      cmd_en_q <= 1'b0;
      irst_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      tmo_q    <= tmo_d;
      rcnt_q   <= rcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wdo_q    <= wdo_d;
      cmd_q    <= cmd_d;
      cmd_en_q <= cmd_en_d;
      irst_n_q <= irst_n_d;
    end
  end

  // Request fields are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (lat_en) begin
      rnw_q <= rnw;
      dev_q <= dev_addr;
      reg_q <= reg_addr;
      wd_q  <= wdata;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign i2c_cmd     = cmd_q;
  assign i2c_cmd_en  = cmd_en_q;
  assign i2c_wdata   = wdo_q;
  assign i2c_reset_n = irst_n_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
module tb_i2c_reg_seq;
  localparam int TMO = 16;
  localparam int RST = 2;

  logic       clk_i = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0, rnw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wdata = '0;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic [3:0] i2c_cmd;
  logic       i2c_cmd_en;
  logic [7:0] i2c_wdata;
  logic [7:0] i2c_rdata;
  logic       i2c_data_valid;
  logic       i2c_ready;
  logic       i2c_reset_n;

  i2c_reg_seq #(.TIMEOUT(TMO), .RST_CYCLES(RST)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .req(req), .rnw(rnw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .i2c_cmd(i2c_cmd), .i2c_cmd_en(i2c_cmd_en), .i2c_wdata(i2c_wdata),
    .i2c_rdata(i2c_rdata), .i2c_data_valid(i2c_data_valid),
    .i2c_ready(i2c_ready), .i2c_reset_n(i2c_reset_n)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [3:0] c; logic [7:0] d; bit m; } cmd_t;
  typedef struct { bit e; logic [7:0] r; } done_t;
  cmd_t  exp_cmd[$];
  done_t exp_done[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rst_low = 0;

  // engine model controls
  int         hang_idx = -1;
  bit         novalid = 1'b0;
  logic [7:0] rd_val = 8'h71;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
    end
  endtask

  // Byte-level engine model: ready stays high for the cycle of the strobe,
  // drops for a few cycles, then rises (with data_valid on a READ).
  initial begin : engine
    int phase, cnt, cmd_idx;
    bit hang_now;
    logic [3:0] cur;
    phase = 0; cnt = 0; cmd_idx = 0; hang_now = 1'b0; cur = '0;
    i2c_ready = 1'b1; i2c_data_valid = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!reset_n || !i2c_reset_n) begin
        i2c_ready = 1'b1; i2c_data_valid = 1'b0; phase = 0; hang_now = 1'b0;
      end else begin
        if (!busy) cmd_idx = 0;
        if (i2c_cmd_en) begin
          cur = i2c_cmd;
          hang_now = (cmd_idx == hang_idx);
          cmd_idx++;
          phase = 1;
          i2c_data_valid = 1'b0;
        end else if (phase == 1) begin
          i2c_ready = 1'b0; cnt = 3; phase = 2;
        end else if (phase == 2 && !hang_now) begin
          cnt--;
          if (cnt == 0) begin
            i2c_ready = 1'b1;
            phase = 0;
            if (cur == 4'd4) begin
              i2c_data_valid = !novalid;
              i2c_rdata = rd_val;
            end
          end
        end
      end
    end
  end

  // Monitor: pops expected commands on every strobe and expected
  // completions on every done pulse.
  initial begin : monitor
    cmd_t  ec;
    done_t ed;
    forever begin
      @(negedge clk_i);
      if (reset_n) begin
        if (!i2c_reset_n) rst_low++;
        if (i2c_cmd_en) begin
          if (exp_cmd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd actual=%0h required=none", i2c_cmd);
          end else begin
            ec = exp_cmd.pop_front();
            chk("cmd", {28'd0, i2c_cmd}, {28'd0, ec.c});
            if (ec.m) chk("cmd_data", {24'd0, i2c_wdata}, {24'd0, ec.d});
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            ed = exp_done.pop_front();
            chk("done_err", {31'd0, err}, {31'd0, ed.e});
            chk("done_rdata", {24'd0, rdata}, {24'd0, ed.r});
            chk("rst_low_cycles", rst_low, ed.e ? RST : 0);
          end
          rst_low = 0;
        end
      end
    end
  end

  task automatic push_c(input logic [3:0] c, input logic [7:0] d, input bit m);
    cmd_t e;
    e.c = c; e.d = d; e.m = m;
    exp_cmd.push_back(e);
  endtask

  // Push the first ncmd commands of a transaction plus its completion.
  task automatic push_txn(input bit r, input logic [6:0] dv, input logic [7:0] ra,
                          input logic [7:0] wd, input int ncmd, input bit e_err,
                          input logic [7:0] e_rd);
    cmd_t  l[$];
    cmd_t  e;
    done_t d;
    e.m = 1'b0; e.d = 8'h00; e.c = 4'd1; l.push_back(e);
    e.m = 1'b1; e.c = 4'd3; e.d = {dv, 1'b0}; l.push_back(e);
    e.d = ra; l.push_back(e);
    if (r) begin
      e.m = 1'b0; e.c = 4'd1; e.d = 8'h00; l.push_back(e);
      e.m = 1'b1; e.c = 4'd3; e.d = {dv, 1'b1}; l.push_back(e);
      e.m = 1'b0; e.c = 4'd4; e.d = 8'h00; l.push_back(e);
    end else begin
      e.d = wd; l.push_back(e);
    end
    e.m = 1'b0; e.c = 4'd2; e.d = 8'h00; l.push_back(e);
    for (int i = 0; i < ncmd && i < l.size(); i++) push_c(l[i].c, l[i].d, l[i].m);
    d.e = e_err; d.r = e_rd;
    exp_done.push_back(d);
  endtask

  task automatic start_txn(input bit r, input logic [6:0] dv, input logic [7:0] ra,
                           input logic [7:0] wd);
    @(negedge clk_i);
    rnw = r; dev_addr = dv; reg_addr = ra; wdata = wd; req = 1'b1;
    @(negedge clk_i);
    req = 1'b0;
    chk("busy_set", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (exp_done.size() != 0 && n < 2000) begin
      @(negedge clk_i); n++;
    end
    if (exp_done.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=pending required=done", nm);
      exp_done.delete(); exp_cmd.delete();
    end
    chk({nm, "_cmds_left"}, exp_cmd.size(), 0);
    @(negedge clk_i);
    chk({nm, "_busy_clr"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {busy, done, err, rdata, i2c_cmd, i2c_cmd_en, i2c_wdata, i2c_reset_n},
        {3'b000, 8'h00, 4'h0, 1'b0, 8'h00, 1'b1});
  endtask

  initial begin : stim
    int gap, dsnap, n;
    #12;
    chk_reset_vals("reset_values");
    @(negedge clk_i); reset_n = 1'b1;

    // Register write
    push_txn(1'b0, 7'h1D, 8'h2A, 8'h5C, 5, 1'b0, 8'h00);
    start_txn(1'b0, 7'h1D, 8'h2A, 8'h5C);
    wait_idle("write");

    // Register read
    rd_val = 8'h71;
    push_txn(1'b1, 7'h68, 8'h75, 8'h00, 7, 1'b0, 8'h71);
    start_txn(1'b1, 7'h68, 8'h75, 8'h00);
    wait_idle("read");

    // Engine hangs on SEND reg_addr: abort, rdata kept
    hang_idx = 2;
    push_txn(1'b0, 7'h1D, 8'h2A, 8'h5C, 3, 1'b1, 8'h71);
    start_txn(1'b0, 7'h1D, 8'h2A, 8'h5C);
    wait_idle("timeout");
    hang_idx = -1;

    // READ completes without data_valid: abort, rdata kept
    novalid = 1'b1; rd_val = 8'h99;
    push_txn(1'b1, 7'h68, 8'h75, 8'h00, 6, 1'b1, 8'h71);
    start_txn(1'b1, 7'h68, 8'h75, 8'h00);
    wait_idle("novalid");
    novalid = 1'b0; rd_val = 8'h71;

    // Busy ignore and back-to-back
    dsnap = done_cnt;
    push_txn(1'b0, 7'h11, 8'h01, 8'hA1, 5, 1'b0, 8'h71);
    push_txn(1'b0, 7'h12, 8'h02, 8'hB2, 5, 1'b0, 8'h71);
    start_txn(1'b0, 7'h11, 8'h01, 8'hA1);
    n = 0;
    while (exp_cmd.size() > 8 && n < 500) begin @(negedge clk_i); n++; end
    rnw = 1'b0; dev_addr = 7'h12; reg_addr = 8'h02; wdata = 8'hB2; req = 1'b1;
    n = 0;
    while (!done && n < 500) begin @(negedge clk_i); n++; end
    gap = 0;
    @(negedge clk_i);
    while (!busy && gap < 20) begin gap++; @(negedge clk_i); end
    req = 1'b0;
    chk("b2b_idle_gap", gap, 1);
    wait_idle("b2b");
    chk("b2b_done_count", done_cnt - dsnap, 2);

    // Reset during SEND reg_addr
    dsnap = done_cnt;
    push_txn(1'b0, 7'h1D, 8'h2A, 8'h5C, 5, 1'b0, 8'h71);
    start_txn(1'b0, 7'h1D, 8'h2A, 8'h5C);
    n = 0;
    while (exp_cmd.size() > 2 && n < 500) begin @(negedge clk_i); n++; end
    @(posedge clk_i); #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midop_reset_values");
    exp_cmd.delete(); exp_done.delete();
    repeat (3) @(negedge clk_i);
    chk_reset_vals("held_reset_values");
    reset_n = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("midop_no_done", done_cnt - dsnap, 0);

    // Fresh write after reset
    push_txn(1'b0, 7'h1D, 8'h2A, 8'h5C, 5, 1'b0, 8'h00);
    start_txn(1'b0, 7'h1D, 8'h2A, 8'h5C);
    wait_idle("post_reset_write");

    repeat (4) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
